bch_decode_ctrl: RTL and testbench

Top-level sequencer for one 64-bit BCH codeword decode over GF(2^6). It latches the codeword, then runs three engines in order: syndrome unit, key-equation (locator polynomial) unit, and the error_location Chien-search unit. It validates the locator result, applies the correction by XOR, and reports status to the storage read-path controller. The engines themselves sit outside this block; it only drives their start/finish handshakes.

---
 rtl/bch_pkg.sv | 44 ++++
 rtl/bch_decode_ctrl_if.sv | 32 +++
 rtl/popcount64.sv | 15 +
 rtl/bch_decode_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bch_decode_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bch_pkg.sv
// Shared definitions for the BCH decode sequencer.
// Contents: codeword/locator widths, watchdog limit, GF(2^6) constants,
// FSM state enum, result status codes and the locator degree helper.
package bch_pkg;

  localparam int N           = 64;    // codeword width in bits
  localparam int GF_M        = 6;     // bits per GF(2^6) coefficient
  localparam int T_MAX       = 8;     // highest locator coefficient index
  localparam int POLY_W      = 54;    // (T_MAX+1) coefficients of GF_M bits
  localparam int TIMEOUT_CYC = 1023;  // engine-wait watchdog limit
  localparam int WD_W        = 10;    // watchdog counter width

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYN_L,
    ST_SYN_W,
    ST_KEQ_L,
    ST_KEQ_W,
    ST_LOC_L,
    ST_LOC_W,
    ST_CHECK,
    ST_CORR,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    STAT_CLEAN  = 2'b00,
    STAT_CORR   = 2'b01,
    STAT_UNCORR = 2'b10,
    STAT_TMO    = 2'b11
  } status_t;

  // Index of the highest nonzero coefficient; an all-zero or constant
  // polynomial reports degree 0.
  function automatic logic [3:0] poly_degree(input logic [POLY_W-1:0] poly);
    logic [3:0] deg;
    deg = 4'd0;
    for (int i = 1; i <= T_MAX; i++) begin
      if (poly[i*GF_M +: GF_M] != '0) deg = 4'(i);
    end
    return deg;
  endfunction

endpackage

// File: rtl/bch_decode_ctrl_if.sv
// Start/finish handshakes between the decode sequencer and its three
// external engines (syndrome, key-equation, error_location).
// master: the sequencer (drives *_start and loc_poly).
// slave : the engine side (drives finish levels and results).
interface bch_decode_ctrl_if;
  import bch_pkg::*;

  logic              syn_start;
  logic              syn_finish;
  logic              syn_zero;
  logic              keq_start;
  logic              keq_finish;
  logic              keq_fail;
  logic [POLY_W-1:0] keq_poly;
  logic              loc_start;
  logic [POLY_W-1:0] loc_poly;
  logic              loc_finish;
  logic [N-1:0]      loc_position;

  modport master (
    output syn_start, keq_start, loc_start, loc_poly,
    input  syn_finish, syn_zero, keq_finish, keq_fail, keq_poly,
           loc_finish, loc_position
  );

  modport slave (
    input  syn_start, keq_start, loc_start, loc_poly,
    output syn_finish, syn_zero, keq_finish, keq_fail, keq_poly,
           loc_finish, loc_position
  );

endinterface

// File: rtl/popcount64.sv
// Combinational population count of a 64-bit vector.
// Ports: bits (64-bit input), count (7-bit number of set bits).
module popcount64 (
  input  logic [63:0] bits,
  output logic [6:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 64; i++) begin
      count = count + 7'(bits[i]);
    end
  end

endmodule

// File: rtl/bch_decode_ctrl.sv
// Sequencer for one 64-bit BCH codeword decode: launches the syndrome,
// key-equation and error_location engines in turn, validates the locator
// against the error bitmap, applies the XOR correction and reports status.
// Ports:
//   clk, resetN             clock, asynchronous active-low reset
//   start, codeword         decode request (edge) and received word
//   eng                     engine handshakes (master side)
//   busy                    accepted start until DONE (exclusive)
//   finishFlag              one-cycle result-ready pulse
//   corrected, errorCount   corrected word and applied error count
//   status                  00 clean, 01 corrected, 10 uncorrectable, 11 timeout
module bch_decode_ctrl
  import bch_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               start,
  input  logic [N-1:0]       codeword,
  bch_decode_ctrl_if.master  eng,
  output logic               busy,
  output logic               finishFlag,
  output logic [N-1:0]       corrected,
  output logic [6:0]         errorCount,
  output logic [1:0]         status
);

  state_t          state;
  status_t         status_reg;
  logic            start_d;
  logic [N-1:0]    cw_reg;
  logic [N-1:0]    pos_reg;
  logic [3:0]      deg_reg;
  logic [6:0]      cnt_reg;
  logic [WD_W-1:0] wd_reg;
  logic [6:0]      pos_cnt;

  logic            start_edge;
  logic            in_wait;
  logic            fin_now;
  logic            sample;
  logic            timeout;
  logic            early_done;
  status_t         early_stat;

  popcount64 u_popcount (
    .bits  (pos_reg),
    .count (pos_cnt)
  );

  assign start_edge = start & ~start_d;
  assign status     = status_reg;
  assign in_wait    = (state == ST_SYN_W) || (state == ST_KEQ_W) || (state == ST_LOC_W);

  always_comb begin
    fin_now = 1'b0;
    case (state)
      ST_SYN_W: fin_now = eng.syn_finish;
      ST_KEQ_W: fin_now = eng.keq_finish;
      ST_LOC_W: fin_now = eng.loc_finish;
      default:  fin_now = 1'b0;
    endcase
  end

  // Finish levels can be left high by the previous run, so the first wait
  // cycle (watchdog still at zero) never samples them.
  assign sample  = in_wait && (wd_reg != '0) && fin_now;
  assign timeout = in_wait && !sample && (wd_reg == WD_W'(TIMEOUT_CYC));

  // Every exit to DONE that returns the raw codeword uncorrected.
  always_comb begin
    early_done = 1'b0;
    early_stat = STAT_CLEAN;
    if (timeout) begin
      early_done = 1'b1;
      early_stat = STAT_TMO;
    end else if (sample && (state == ST_SYN_W) && eng.syn_zero) begin
      early_done = 1'b1;
      early_stat = STAT_CLEAN;
    end else if (sample && (state == ST_KEQ_W) && eng.keq_fail) begin
      early_done = 1'b1;
      early_stat = STAT_UNCORR;
    end else if ((state == ST_CHECK) &&
                 ((deg_reg == 4'd0) || ({3'b000, deg_reg} != pos_cnt))) begin
      early_done = 1'b1;
      early_stat = STAT_UNCORR;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= ST_IDLE;
      status_reg    <= STAT_CLEAN;
      start_d       <= 1'b0;
      cw_reg        <= '0;
      pos_reg       <= '0;
      deg_reg       <= '0;
      cnt_reg       <= '0;
      wd_reg        <= '0;
      busy          <= 1'b0;
      finishFlag    <= 1'b0;
      corrected     <= '0;
      errorCount    <= '0;
      eng.syn_start <= 1'b0;
      eng.keq_start <= 1'b0;
      eng.loc_start <= 1'b0;
      eng.loc_poly  <= '0;
    end else begin
      start_d       <= start;
      eng.syn_start <= 1'b0;
      eng.keq_start <= 1'b0;
      eng.loc_start <= 1'b0;
      finishFlag    <= 1'b0;

      if (early_done) begin
        corrected  <= cw_reg;
        errorCount <= '0;
        status_reg <= early_stat;
        busy       <= 1'b0;
        finishFlag <= 1'b1;
        state      <= ST_DONE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_edge) begin
              cw_reg        <= codeword;
              corrected     <= '0;
              errorCount    <= '0;
              status_reg    <= STAT_CLEAN;
              busy          <= 1'b1;
              eng.syn_start <= 1'b1;
              state         <= ST_SYN_L;
            end
          end
          ST_SYN_L: begin
            wd_reg <= '0;
            state  <= ST_SYN_W;
          end
          ST_SYN_W: begin
            if (sample) begin
              eng.keq_start <= 1'b1;
              state         <= ST_KEQ_L;
            end else begin
              wd_reg <= wd_reg + 1'b1;
            end
          end
          ST_KEQ_L: begin
            wd_reg <= '0;
            state  <= ST_KEQ_W;
          end
          ST_KEQ_W: begin
            if (sample) begin
              eng.loc_poly  <= eng.keq_poly;
              deg_reg       <= poly_degree(eng.keq_poly);
              eng.loc_start <= 1'b1;
              state         <= ST_LOC_L;
            end else begin
              wd_reg <= wd_reg + 1'b1;
            end
          end
          ST_LOC_L: begin
            wd_reg <= '0;
            state  <= ST_LOC_W;
          end
          ST_LOC_W: begin
            if (sample) begin
              pos_reg <= eng.loc_position;
              state   <= ST_CHECK;
            end else begin
              wd_reg <= wd_reg + 1'b1;
            end
          end
          ST_CHECK: begin
            // Degree agreed with the bitmap; keep the count for CORR.
            cnt_reg <= pos_cnt;
            state   <= ST_CORR;
          end
          ST_CORR: begin
            corrected  <= cw_reg ^ pos_reg;
            errorCount <= cnt_reg;
            status_reg <= STAT_CORR;
            busy       <= 1'b0;
            finishFlag <= 1'b1;
            state      <= ST_DONE;
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// Self-checking bench for bch_decode_ctrl: the bench plays the three
// engines (leaving finish levels high between runs, scrambling data in the
// ignored first wait cycle) and compares against a behavioural model.
module tb_bch_decode_ctrl;
  import bch_pkg::*;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] codeword = '0;
  logic         busy;
  logic         finishFlag;
  logic [N-1:0] corrected;
  logic [6:0]   errorCount;
  logic [1:0]   status;

  bch_decode_ctrl_if eng();

  bch_decode_ctrl dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .codeword   (codeword),
    .eng        (eng),
    .busy       (busy),
    .finishFlag (finishFlag),
    .corrected  (corrected),
    .errorCount (errorCount),
    .status     (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_syn = 0, n_keq = 0, n_loc = 0, n_flag = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng.syn_start) n_syn++;
    if (eng.keq_start) n_keq++;
    if (eng.loc_start) n_loc++;
    if (finishFlag)    n_flag++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic get_start(input int sel);
    case (sel)
      0:       return eng.syn_start;
      1:       return eng.keq_start;
      default: return eng.loc_start;
    endcase
  endfunction

  function automatic logic get_fin(input int sel);
    case (sel)
      0:       return eng.syn_finish;
      1:       return eng.keq_finish;
      default: return eng.loc_finish;
    endcase
  endfunction

  task automatic drive_eng(input int sel, input logic fin, input logic [63:0] data);
    case (sel)
      0: begin
        eng.syn_finish = fin;
        eng.syn_zero   = data[0];
      end
      1: begin
        eng.keq_finish = fin;
        eng.keq_fail   = data[POLY_W];
        eng.keq_poly   = data[POLY_W-1:0];
      end
      default: begin
        eng.loc_finish   = fin;
        eng.loc_position = data;
      end
    endcase
  endtask

  // One engine: wait for its start pulse, keep the old finish level with
  // garbage data through the first wait cycle, then answer with real data.
  task automatic run_eng(input int sel, input logic [63:0] data, input bit hang, input bit poke,
                         output int st_cyc, output int raise_cyc, output bit seen);
    int d;
    seen = 1'b0;
    st_cyc = 0;
    raise_cyc = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      if (get_start(sel)) seen = 1'b1;
    end
    if (!seen) return;
    st_cyc = cyc;
    drive_eng(sel, get_fin(sel), {$urandom, $urandom});
    tick();
    if (poke) start = 1'b1;
    tick();
    d = $urandom_range(0, 3);
    if (hang || d > 0) drive_eng(sel, 1'b0, {$urandom, $urandom});
    if (hang) return;
    repeat (d) tick();
    drive_eng(sel, 1'b1, data);
    raise_cyc = cyc;
  endtask

  task automatic run_tx(input string name, input logic [63:0] cw, input bit zero, input bit fail,
                        input logic [POLY_W-1:0] poly, input logic [63:0] pos,
                        input bit hang, input bit poke);
    logic [1:0]  e_st;
    logic [63:0] e_corr;
    logic [6:0]  e_cnt;
    int e_lat, deg, cnt, lat, sc, sc2, rc;
    int b_syn, b_keq, b_loc, b_flag;
    bit seen, got;

    // Reference model straight from the decode rules.
    deg = 0;
    for (int i = 0; i <= T_MAX; i++)
      if (((poly >> (GF_M * i)) & 54'h3F) != 54'd0) deg = i;
    cnt    = $countones(pos);
    e_corr = cw;
    e_cnt  = 7'd0;
    e_lat  = 1;
    if (hang) e_st = 2'b11;
    else if (zero) e_st = 2'b00;
    else if (fail) e_st = 2'b10;
    else if (deg == 0 || cnt != deg) begin
      e_st  = 2'b10;
      e_lat = -1;
    end else begin
      e_st   = 2'b01;
      e_corr = cw ^ pos;
      e_cnt  = 7'(cnt);
      e_lat  = 3;
    end

    b_syn = n_syn; b_keq = n_keq; b_loc = n_loc; b_flag = n_flag;
    codeword = cw;
    start    = 1'b1;
    run_eng(0, {63'd0, zero}, hang, 1'b0, sc, rc, seen);
    start = 1'b0;
    check({name, ".syn_start"}, 64'(seen), 64'd1);
    if (!seen) return;
    check({name, ".busy"}, 64'(busy), 64'd1);
    if (!hang && !zero) begin
      run_eng(1, {9'd0, fail, poly}, 1'b0, 1'b0, sc2, rc, seen);
      check({name, ".keq_start"}, 64'(seen), 64'd1);
      if (!seen) return;
      if (!fail) begin
        run_eng(2, pos, 1'b0, poke, sc2, rc, seen);
        check({name, ".loc_start"}, 64'(seen), 64'd1);
        if (!seen) return;
      end
    end

    got = 1'b0;
    for (int i = 0; i < 1200 && !got; i++) begin
      tick();
      if (finishFlag) got = 1'b1;
    end
    check({name, ".finish"}, 64'(got), 64'd1);
    if (got) begin
      if (hang) begin
        lat = cyc - sc;
        check({name, ".tmo_window"}, 64'(lat >= 1020 && lat <= 1030), 64'd1);
      end else begin
        lat = cyc - rc;
        if (e_lat > 0) check({name, ".latency"}, 64'(lat), 64'(e_lat));
        else check({name, ".latency_max"}, 64'(lat <= 3), 64'd1);
      end
      check({name, ".status"}, 64'(status), 64'(e_st));
      check({name, ".corrected"}, corrected, e_corr);
      check({name, ".errcnt"}, 64'(errorCount), 64'(e_cnt));
      check({name, ".busy_done"}, 64'(busy), 64'd0);
      tick();
      check({name, ".flag_pulse"}, 64'(finishFlag), 64'd0);
      check({name, ".hold_status"}, 64'(status), 64'(e_st));
      check({name, ".hold_corr"}, corrected, e_corr);
    end
    repeat (2) tick();
    start = 1'b0;
    repeat (3) tick();
    check({name, ".n_syn"}, 64'(n_syn - b_syn), 64'd1);
    check({name, ".n_keq"}, 64'(n_keq - b_keq), 64'((!hang && !zero) ? 1 : 0));
    check({name, ".n_loc"}, 64'(n_loc - b_loc), 64'((!hang && !zero && !fail) ? 1 : 0));
    check({name, ".n_flag"}, 64'(n_flag - b_flag), 64'd1);
    $display("tx %s cw=%h status=%b errcnt=%0d", name, cw, status, errorCount);
  endtask

  function automatic logic [POLY_W-1:0] make_poly(input int d);
    logic [POLY_W-1:0] p;
    int c;
    p = '0;
    for (int i = 0; i <= d; i++) begin
      c = (i == d) ? $urandom_range(1, 63) : $urandom_range(0, 63);
      p = p | (POLY_W'(c) << (GF_M * i));
    end
    return p;
  endfunction

  function automatic logic [63:0] make_pos(input int k);
    logic [63:0] p;
    p = '0;
    while ($countones(p) < k) p[$urandom_range(0, 63)] = 1'b1;
    return p;
  endfunction

  initial begin
    logic [POLY_W-1:0] poly;
    logic [63:0] pos;
    int kind, d, k, b_flag, b_syn, sc, rc;
    bit seen, got;

    eng.syn_finish = 1'b0; eng.syn_zero = 1'b0;
    eng.keq_finish = 1'b0; eng.keq_fail = 1'b0; eng.keq_poly = '0;
    eng.loc_finish = 1'b0; eng.loc_position = '0;

    repeat (3) tick();
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.flag", 64'(finishFlag), 64'd0);
    check("rst.status", 64'(status), 64'd0);
    check("rst.corrected", corrected, 64'd0);
    check("rst.errcnt", 64'(errorCount), 64'd0);
    check("rst.syn_start", 64'(eng.syn_start), 64'd0);
    resetN = 1'b1;
    repeat (2) tick();

    run_tx("clean", {$urandom, $urandom}, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    poly = 54'h1 | (54'h12 << 6) | (54'h07 << 12);
    run_tx("two_err", {$urandom, $urandom}, 1'b0, 1'b0, poly, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
    run_tx("stale", {$urandom, $urandom}, 1'b0, 1'b0, poly, 64'h0000_0100_0000_0020, 1'b0, 1'b0);
    run_tx("mismatch", {$urandom, $urandom}, 1'b0, 1'b0, make_poly(3), make_pos(2), 1'b0, 1'b0);
    run_tx("deg0", {$urandom, $urandom}, 1'b0, 1'b0, 54'h1, '0, 1'b0, 1'b0);
    run_tx("keq_fail", {$urandom, $urandom}, 1'b0, 1'b1, make_poly(2), make_pos(2), 1'b0, 1'b0);
    run_tx("restart", {$urandom, $urandom}, 1'b0, 1'b0, make_poly(4), make_pos(4), 1'b0, 1'b1);
    run_tx("timeout", {$urandom, $urandom}, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Reset while waiting on the key-equation engine.
    b_flag = n_flag;
    b_syn  = n_syn;
    codeword = {$urandom, $urandom};
    start = 1'b1;
    run_eng(0, 64'd0, 1'b0, 1'b0, sc, rc, seen);
    start = 1'b0;
    check("rstmid.syn_start", 64'(seen), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      if (eng.keq_start) seen = 1'b1;
    end
    check("rstmid.keq_start", 64'(seen), 64'd1);
    repeat (2) tick();
    resetN = 1'b0;
    #1;
    check("rstmid.busy", 64'(busy), 64'd0);
    check("rstmid.status", 64'(status), 64'd0);
    check("rstmid.corrected", corrected, 64'd0);
    check("rstmid.loc_poly", 64'(eng.loc_poly), 64'd0);
    repeat (2) tick();
    resetN = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (finishFlag) got = 1'b1;
    end
    check("rstmid.no_flag", 64'(got), 64'd0);
    check("rstmid.n_flag", 64'(n_flag - b_flag), 64'd0);
    check("rstmid.n_syn", 64'(n_syn - b_syn), 64'd1);
    $display("tx rst_mid status=%b busy=%b", status, busy);

    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_tx($sformatf("rnd%0d", t), {$urandom, $urandom}, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        1: run_tx($sformatf("rnd%0d", t), {$urandom, $urandom}, 1'b0, 1'b1, make_poly(3), '0, 1'b0, 1'b0);
        2: begin
          d = $urandom_range(1, 8);
          run_tx($sformatf("rnd%0d", t), {$urandom, $urandom}, 1'b0, 1'b0, make_poly(d), make_pos(d), 1'b0, 1'b0);
        end
        default: begin
          d = $urandom_range(0, 8);
          k = $urandom_range(0, 8);
          if (k == d && d != 0) k = (d % 8) + 1;
          run_tx($sformatf("rnd%0d", t), {$urandom, $urandom}, 1'b0, 1'b0, make_poly(d), make_pos(k), 1'b0, 1'b0);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
